vga_vblank_arbiter: RTL and testbench

- Arbitrates write access to the shared display register bank between two requesters: the ADC sample updater (port 0) and the UI/config updater (port 1).
- Writes are granted only inside a vertical-blanking window, so digits and colours never change mid-frame and the picture does not tear.
- Sits beside the VGA sync generator and consumes its free-running `h`/`v` counters.
- Drives the register bank's single write port.

---
 rtl/vga_vblank_arbiter_if.sv | 33 +++
 rtl/vga_vblank_arbiter.sv | 119 +++++++++++
 tb/tb_vga_vblank_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_vblank_arbiter_if.sv
// Bus between the sync generator / two register-bank writers and the blanking arbiter.
// Handshake: reqN is a level held with addrN/dataN stable until ackN pulses for one cycle.
interface vga_vblank_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 12
);
    logic [9:0]        h;
    logic [9:0]        v;
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;
    logic              ack0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;
    logic              ack1;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              window;
    logic              frame_start;
    logic              late;

    modport master (
        output h, v, req0, addr0, data0, req1, addr1, data1,
        input  ack0, ack1, wr_en, wr_addr, wr_data, window, frame_start, late
    );

    modport slave (
        input  h, v, req0, addr0, data0, req1, addr1, data1,
        output ack0, ack1, wr_en, wr_addr, wr_data, window, frame_start, late
    );
endinterface

// File: rtl/vga_vblank_arbiter.sv
// Grants register-bank writes from two requesters only during vertical blanking,
// round-robin between them, so display registers never change mid-frame.
module vga_vblank_arbiter #(
    parameter int V_DISPLAY   = 480,
    parameter int V_MAX       = 524,
    parameter int GUARD_LINES = 2,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_vblank_arbiter_if.slave  bus,
    output logic [1:0]           state_o
);
    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SCAN       = 2'd1,
        OPEN       = 2'd2,
        CLOSED     = 2'd3
    } state_t;

    localparam logic [9:0] V_OPEN  = 10'(V_DISPLAY);
    localparam logic [9:0] V_CLOSE = 10'(V_MAX - GUARD_LINES);

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic              ack0_q, ack1_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              window_q;
    logic              frame_start_q;
    logic              late_q, late_d;

    logic origin, open_hit, close_hit;
    logic el0, el1, gnt0, gnt1;

    assign origin    = (bus.h == 10'd0) && (bus.v == 10'd0);
    assign open_hit  = (bus.h == 10'd0) && (bus.v == V_OPEN);
    assign close_hit = (bus.h == 10'd0) && (bus.v == V_CLOSE);

    always_comb begin
        state_d   = state_q;
        late_d    = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rr_d      = rr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // A port acked this cycle is presenting a consumed request; skip it once.
        el0 = bus.req0 && (state_q == OPEN) && !ack0_q;
        el1 = bus.req1 && (state_q == OPEN) && !ack1_q;

        case (state_q)
            WAIT_FRAME: if (origin)    state_d = SCAN;
            SCAN:       if (open_hit)  state_d = OPEN;
            OPEN: begin
                if (close_hit) begin
                    state_d = CLOSED;
                    late_d  = el0 || el1;
                end
            end
            CLOSED:     if (origin)    state_d = SCAN;
            default:                   state_d = WAIT_FRAME;
        endcase

        // rr_q == 1 means port 1 was granted last, so port 0 wins a tie.
        if ((state_q == OPEN) && !close_hit) begin
            gnt0 = el0 && (!el1 || rr_q);
            gnt1 = el1 && (!el0 || !rr_q);
        end

        if (gnt0) begin
            rr_d      = 1'b0;
            wr_addr_d = bus.addr0;
            wr_data_d = bus.data0;
        end else if (gnt1) begin
            rr_d      = 1'b1;
            wr_addr_d = bus.addr1;
            wr_data_d = bus.data1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= WAIT_FRAME;
            rr_q          <= 1'b1;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            window_q      <= 1'b0;
            frame_start_q <= 1'b0;
            late_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            ack0_q        <= gnt0;
            ack1_q        <= gnt1;
            wr_en_q       <= gnt0 || gnt1;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            window_q      <= (state_d == OPEN);
            frame_start_q <= origin;
            late_q        <= late_d;
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.window      = window_q;
    assign bus.frame_start = frame_start_q;
    assign bus.late        = late_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_vga_vblank_arbiter.sv
// Bench for the blanking-window arbiter on a shrunken raster (8 pixels x 30 lines)
// driven by an in-bench sync counter.
module tb_vga_vblank_arbiter;
    localparam int H_TOTAL = 8;
    localparam int V_DISP  = 20;
    localparam int V_MAXL  = 29;
    localparam int GUARD   = 2;
    localparam int CLOSE_V = V_MAXL - GUARD;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;

    vga_vblank_arbiter_if #(.ADDR_W(4), .DATA_W(12)) bus();

    vga_vblank_arbiter #(
        .V_DISPLAY(V_DISP), .V_MAX(V_MAXL), .GUARD_LINES(GUARD),
        .ADDR_W(4), .DATA_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .state_o(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1;
        logic [3:0]  a0;
        logic [11:0] d0;
        logic [3:0]  a1;
        logic [11:0] d1;
        logic        e0, e1;
    } vec_t;

    vec_t        vecs[15];
    logic [16:0] exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          n_ack0 = 0, n_ack1 = 0, n_wr = 0, n_late = 0, n_fs = 0;
    logic        m_seen = 1'b0, m_win = 1'b0, m_fs = 1'b0;

    function automatic vec_t mk(logic r0, logic r1, logic [3:0] a0, logic [11:0] d0,
                                logic [3:0] a1, logic [11:0] d1, logic e0, logic e1);
        vec_t t;
        t.r0 = r0; t.r1 = r1; t.a0 = a0; t.d0 = d0;
        t.a1 = a1; t.d1 = d1; t.e0 = e0; t.e1 = e1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d t=%0t)", name, act, exp, bus.h, bus.v, $time);
        end
    endtask

    // One clock: sample after the edge, check against the raster model, then advance h/v.
    task automatic tick();
        logic [9:0]  sh, sv;
        logic        sr;
        logic [16:0] e;
        sh = bus.h; sv = bus.v; sr = rst_n;
        @(posedge clk);
        #1;
        if (!sr) begin
            m_seen = 1'b0; m_win = 1'b0; m_fs = 1'b0;
        end else begin
            m_fs = (sh == 10'd0) && (sv == 10'd0);
            if (m_fs) m_seen = 1'b1;
            if (m_seen && sh == 10'd0 && sv == 10'(V_DISP)) m_win = 1'b1;
            if (sh == 10'd0 && sv == 10'(CLOSE_V)) m_win = 1'b0;
        end
        chk("window", {31'd0, bus.window}, {31'd0, m_win});
        chk("frame_start", {31'd0, bus.frame_start}, {31'd0, m_fs});
        chk("one_grant", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
        chk("wr_en_vs_ack", {31'd0, bus.wr_en}, {31'd0, bus.ack0 | bus.ack1});
        chk("ack_in_window", {31'd0, (bus.ack0 | bus.ack1) & ~m_win}, 32'd0);
        if (bus.ack0) n_ack0++;
        if (bus.ack1) n_ack1++;
        if (bus.late) n_late++;
        if (bus.frame_start) n_fs++;
        if (bus.wr_en) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_write", {15'd0, bus.ack1, bus.wr_addr, bus.wr_data}, 32'h1ffff);
            end else begin
                e = exp_q.pop_front();
                chk("sb_write", {15'd0, bus.ack1, bus.wr_addr, bus.wr_data}, {15'd0, e});
            end
        end
        if (bus.h == 10'(H_TOTAL - 1)) begin
            bus.h = 10'd0;
            bus.v = (bus.v == 10'(V_MAXL)) ? 10'd0 : bus.v + 10'd1;
        end else begin
            bus.h = bus.h + 10'd1;
        end
    endtask

    task automatic goto(input int tv, input int th);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.h == 10'(th) && bus.v == 10'(tv)) && n < 4000);
        if (n >= 4000) chk("goto_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int a0c, a1c, wc, fsc, lc;

        vecs[0]  = mk(0, 0, 4'd0, 12'h000, 4'd0, 12'h000, 0, 0);
        vecs[1]  = mk(1, 0, 4'd3, 12'hABC, 4'd0, 12'h000, 1, 0);
        vecs[2]  = mk(1, 0, 4'd3, 12'hABC, 4'd0, 12'h000, 0, 0);
        vecs[3]  = mk(1, 0, 4'd3, 12'hABC, 4'd0, 12'h000, 1, 0);
        vecs[4]  = mk(1, 0, 4'd3, 12'hABC, 4'd0, 12'h000, 0, 0);
        vecs[5]  = mk(0, 1, 4'd0, 12'h000, 4'd2, 12'h222, 0, 1);
        vecs[6]  = mk(0, 0, 4'd0, 12'h000, 4'd0, 12'h000, 0, 0);
        vecs[7]  = mk(1, 1, 4'd1, 12'h111, 4'd2, 12'h222, 1, 0);
        vecs[8]  = mk(1, 1, 4'd1, 12'h111, 4'd2, 12'h222, 0, 1);
        vecs[9]  = mk(1, 1, 4'd1, 12'h111, 4'd2, 12'h222, 1, 0);
        vecs[10] = mk(1, 1, 4'd1, 12'h111, 4'd2, 12'h222, 0, 1);
        vecs[11] = mk(0, 0, 4'd0, 12'h000, 4'd0, 12'h000, 0, 0);
        vecs[12] = mk(0, 1, 4'd0, 12'h000, 4'd7, 12'h777, 0, 1);
        vecs[13] = mk(1, 1, 4'd1, 12'h111, 4'd7, 12'h777, 1, 0);
        vecs[14] = mk(0, 0, 4'd0, 12'h000, 4'd0, 12'h000, 0, 0);

        rst_n = 1'b0;
        bus.h = 10'd0; bus.v = 10'd0;
        bus.req0 = 1'b0; bus.addr0 = 4'd0; bus.data0 = 12'd0;
        bus.req1 = 1'b0; bus.addr1 = 4'd0; bus.data1 = 12'd0;

        // Reset held across a frame origin: everything must read zero.
        repeat (3) tick();
        chk("rst_ack0", {31'd0, bus.ack0}, 32'd0);
        chk("rst_ack1", {31'd0, bus.ack1}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
        chk("rst_wr_addr", {28'd0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", {20'd0, bus.wr_data}, 32'd0);
        chk("rst_late", {31'd0, bus.late}, 32'd0);
        chk("rst_state", {30'd0, state_dbg}, 32'd0);

        // Release mid-frame with req0 held: no grant until a full origin has passed.
        goto(5, 0);
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.addr0 = 4'd5; bus.data0 = 12'h155;
        goto(V_DISP, 0);
        chk("no_ack_first_frame", n_ack0, 0);
        tick();
        goto(V_DISP, 0);
        chk("no_ack_before_open", n_ack0, 0);
        exp_q.push_back({1'b0, 4'd5, 12'h155});
        tick();
        chk("open_edge_no_ack", {31'd0, bus.ack0}, 32'd0);
        tick();
        chk("first_ack0", {31'd0, bus.ack0}, 32'd1);
        chk("first_wr_addr", {28'd0, bus.wr_addr}, 32'd5);
        bus.req0 = 1'b0;

        // Table: single-port throughput, round-robin contention, blocked re-request.
        for (int i = 0; i < 15; i++) begin
            bus.req0 = vecs[i].r0; bus.addr0 = vecs[i].a0; bus.data0 = vecs[i].d0;
            bus.req1 = vecs[i].r1; bus.addr1 = vecs[i].a1; bus.data1 = vecs[i].d1;
            if (vecs[i].e0) exp_q.push_back({1'b0, vecs[i].a0, vecs[i].d0});
            if (vecs[i].e1) exp_q.push_back({1'b1, vecs[i].a1, vecs[i].d1});
            tick();
            chk($sformatf("vec%0d_acks", i), {29'd0, bus.ack0, bus.ack1, bus.wr_en},
                {29'd0, vecs[i].e0, vecs[i].e1, vecs[i].e0 | vecs[i].e1});
        end

        // Request pending when the close edge is sampled: late pulses, grant deferred.
        goto(CLOSE_V, 0);
        lc = n_late; a0c = n_ack0;
        bus.req0 = 1'b1; bus.addr0 = 4'd9; bus.data0 = 12'h999;
        tick();
        chk("late_pulse", {31'd0, bus.late}, 32'd1);
        chk("close_no_ack", {31'd0, bus.ack0}, 32'd0);
        goto(V_DISP, 0);
        chk("pending_deferred", n_ack0 - a0c, 0);
        chk("late_once", n_late - lc, 1);
        exp_q.push_back({1'b0, 4'd9, 12'h999});
        tick();
        chk("pending_open_edge", {31'd0, bus.ack0}, 32'd0);
        tick();
        chk("pending_ack0", {31'd0, bus.ack0}, 32'd1);
        bus.req0 = 1'b0;

        // Request raised just after close, held through SCAN: no late, no write.
        goto(CLOSE_V, 0);
        lc = n_late;
        tick();
        chk("close_idle_no_late", {31'd0, bus.late}, 32'd0);
        bus.req1 = 1'b1; bus.addr1 = 4'hA; bus.data1 = 12'hAAA;
        a1c = n_ack1; wc = n_wr; fsc = n_fs;
        goto(V_DISP, 0);
        chk("scan_no_ack1", n_ack1 - a1c, 0);
        chk("scan_no_wr", n_wr - wc, 0);
        chk("fs_once_per_frame", n_fs - fsc, 1);
        chk("after_close_no_late", n_late - lc, 0);
        exp_q.push_back({1'b1, 4'hA, 12'hAAA});
        tick();
        tick();
        chk("deferred_ack1", {31'd0, bus.ack1}, 32'd1);
        bus.req1 = 1'b0;

        // Reset asserted during a grant cycle, then first tie goes to port 0.
        bus.req0 = 1'b1; bus.addr0 = 4'd4; bus.data0 = 12'h444;
        exp_q.push_back({1'b0, 4'd4, 12'h444});
        tick();
        chk("pre_reset_ack0", {31'd0, bus.ack0}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("reset_clears_ack", {30'd0, bus.ack0, bus.wr_en}, 32'd0);
        chk("reset_clears_addr", {16'd0, bus.wr_addr, bus.wr_data}, 32'd0);
        bus.req0 = 1'b0;
        tick();
        rst_n = 1'b1;
        goto(V_DISP, 0);
        bus.req0 = 1'b1; bus.addr0 = 4'd6; bus.data0 = 12'h666;
        bus.req1 = 1'b1; bus.addr1 = 4'd8; bus.data1 = 12'h888;
        exp_q.push_back({1'b0, 4'd6, 12'h666});
        exp_q.push_back({1'b1, 4'd8, 12'h888});
        tick();
        chk("tie_open_edge", {30'd0, bus.ack0, bus.ack1}, 32'd0);
        tick();
        chk("tie_first_port0", {30'd0, bus.ack0, bus.ack1}, 32'd2);
        tick();
        chk("tie_second_port1", {30'd0, bus.ack0, bus.ack1}, 32'd1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        repeat (2) tick();
        chk("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
